port_arbiter2: RTL and testbench
================================

// Module: port_arbiter2
// PURPOSE
// - Two-requester round-robin arbiter for a single shared resource port (e.g. unified memory port shared by IF and MEM stages).
// - Owns the select of the 2:1 data mux in front of the port.
// - Grants one requester at a time, holds the grant until the resource signals DONE, and flags overlong ownership.
// PARAMETERS
// - DATA_W   32  width of the muxed request payload (address/data bundle)
// - TIMEOUT  16  max cycles one grant may be held; 0 disables the watchdog
// - CNT_W    5   width of the hold counter; must hold TIMEOUT
// PORTS
// - CLK    in   1       rising-edge clock (single clock domain)
// - RST_N  in   1       reset, synchronous, active-low
// - REQ    in   2       REQ[i]=1: requester i wants the port; held high until granted and DONE
// - IN0    in   DATA_W  payload of requester 0
// - IN1    in   DATA_W  payload of requester 1
// - DONE   in   1       resource finished the current transfer (1-cycle pulse)
// - GNT    out  2       one-hot grant, registered; 2'b00 when idle
// - SEL    out  1       mux select, registered: 0 -> IN0, 1 -> IN1
// - OUT    out  DATA_W  SEL ? IN1 : IN0 (combinational from registered SEL)
// - BUSY   out  1       |GNT
// - ERR    out  1       1-cycle pulse when the watchdog forces a release
// BEHAVIOUR
// - Reset (RST_N=0 at a rising edge): GNT=00, SEL=0, BUSY=0, ERR=0, hold counter=0, LAST=1. Requester 0 therefore wins the first tie.
// - FSM states: IDLE, OWN0, OWN1. GNT/SEL are decoded from registered state: OWN0 -> GNT=01,SEL=0; OWN1 -> GNT=10,SEL=1.
// - IDLE: REQ=00 -> stay. Exactly one bit set -> OWN of that bit. REQ=11 -> OWN of ~LAST.
// - Grant latency: REQ sampled at edge N, GNT visible after edge N+1 (one cycle).
// - OWNi: stay while REQ[i]=1 and DONE=0. Counter increments each cycle in OWNi and clears on entry.
// - OWNi, release on DONE=1 or REQ[i]=0 (abort): LAST<=i.
//   - If REQ[1-i]=1 in that cycle, go directly to OWN(1-i) (back-to-back, no idle bubble).
//   - Otherwise go to IDLE.
// - Watchdog: TIMEOUT!=0 and counter==TIMEOUT-1 while in OWNi without release -> ERR=1 next cycle, forced release as above. The requester must re-request to be granted again.
// - DONE in IDLE is ignored. DONE coincident with the timeout is a normal release; ERR stays 0.
// - Fairness: with REQ held at 11 and DONE each grant, grants alternate 0,1,0,1; no requester waits more than one full grant of the other.
// - Reset mid-grant: the next edge with RST_N=0 returns to IDLE, GNT=00, SEL=0; in-flight DONE is dropped.
// - GNT is always one-hot or zero; SEL changes only on state change; OUT follows SEL with zero added latency.
// - Counter saturates (no wrap) when TIMEOUT=0.
// TESTING
// - Reset: RST_N=0 two cycles with REQ=11 -> GNT=00, SEL=0, ERR=0; release reset -> GNT=01 one cycle later.
// - Single request: REQ=10, IN1=32'hDEADBEEF -> next cycle GNT=10, SEL=1, OUT=32'hDEADBEEF. DONE pulse -> GNT=00 next cycle.
// - Round robin: REQ=11 held, DONE every 3rd cycle -> grant sequence 01,10,01,10 with no idle cycle between grants.
// - Abort: in OWN0, drop REQ[0] with REQ[1]=1 and DONE=0 -> GNT=10 next cycle, ERR=0.
// - Watchdog: TIMEOUT=4, REQ=01, no DONE -> GNT=01 for 4 cycles, then ERR=1 for exactly 1 cycle, GNT=00. DONE on cycle 4 instead -> ERR stays 0.
// - Reset mid-grant: in OWN1 assert RST_N=0 at the same cycle as DONE -> GNT=00, SEL=0, LAST=1. Then REQ=11 -> GNT=01.

Source files
------------

// File: rtl/port_arbiter2.sv
// port_arbiter2: two-requester round-robin arbiter for one shared resource port.
// It owns the 2:1 payload mux select, holds a grant until the resource reports
// DONE or the owner drops its request, and forces a release (with a one-cycle
// ERR pulse) when a single grant is held for TIMEOUT cycles.
module port_arbiter2 #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [1:0]        REQ,
  input  logic [DATA_W-1:0] IN0,
  input  logic [DATA_W-1:0] IN1,
  input  logic              DONE,
  output logic [1:0]        GNT,
  output logic              SEL,
  output logic [DATA_W-1:0] OUT,
  output logic              BUSY,
  output logic              ERR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // Watchdog fires when the hold counter reaches TIMEOUT-1 without a release.
  localparam logic             WD_EN    = (TIMEOUT != 32'd0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 32'd0) ? 32'd0 : (TIMEOUT - 32'd1));
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              last_q, last_d;      // index of the requester granted most recently
  logic [CNT_W-1:0]  cnt_q, cnt_d;        // cycles spent in the current grant
  logic              err_q, err_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              sel_q, sel_d;

  logic              own_req_s;
  logic              norm_rel_s;
  logic              wd_hit_s;
  logic              rel_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  // Release conditions for the current owner: DONE, abort, or watchdog expiry.
  always_comb begin
    own_req_s  = 1'b0;
    norm_rel_s = 1'b0;
    wd_hit_s   = 1'b0;
    rel_s      = 1'b0;
    if (state_q == ST_OWN1) begin
      own_req_s = REQ[1];
    end else begin
      own_req_s = REQ[0];
    end
    if ((state_q == ST_OWN0) || (state_q == ST_OWN1)) begin
      norm_rel_s = DONE | ~own_req_s;
      // DONE coinciding with expiry counts as a normal release, so no ERR.
      wd_hit_s   = WD_EN & (cnt_q == CNT_LAST) & ~norm_rel_s;
      rel_s      = norm_rel_s | wd_hit_s;
    end else begin
      norm_rel_s = 1'b0;
      wd_hit_s   = 1'b0;
      rel_s      = 1'b0;
    end
  end

  // Saturating increment of the hold counter (matters only with the watchdog off).
  always_comb begin
    cnt_inc_s = cnt_q;
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
  end

  // Next-state logic: arbitration in IDLE, hold/release/hand-over in OWNi.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        case (REQ)
          2'b01:   state_d = ST_OWN0;
          2'b10:   state_d = ST_OWN1;
          // Tie goes to the requester that was not granted last.
          2'b11:   state_d = last_q ? ST_OWN0 : ST_OWN1;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_OWN0: begin
        if (rel_s) begin
          last_d = 1'b0;
          err_d  = wd_hit_s;
          cnt_d  = '0;
          if (REQ[1]) begin
            state_d = ST_OWN1;   // back-to-back hand-over, no idle bubble
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_OWN1: begin
        if (rel_s) begin
          last_d = 1'b1;
          err_d  = wd_hit_s;
          cnt_d  = '0;
          if (REQ[0]) begin
            state_d = ST_OWN0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Grant and mux select are decoded from the next state so they register with it.
  always_comb begin
    gnt_d = 2'b00;
    sel_d = 1'b0;
    case (state_d)
      ST_OWN0: begin
        gnt_d = 2'b01;
        sel_d = 1'b0;
      end
      ST_OWN1: begin
        gnt_d = 2'b10;
        sel_d = 1'b1;
      end
      default: begin
        gnt_d = 2'b00;
        sel_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      gnt_q   <= 2'b00;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  assign GNT  = gnt_q;
  assign SEL  = sel_q;
  assign OUT  = sel_q ? IN1 : IN0;
  assign BUSY = |gnt_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_port_arbiter2.sv
// Bench for port_arbiter2: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the arbitration rules.
module tb_port_arbiter2;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 5;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [1:0]        REQ;
  logic [DATA_W-1:0] IN0, IN1;
  logic              DONE;
  logic [1:0]        GNT;
  logic              SEL;
  logic [DATA_W-1:0] OUT;
  logic              BUSY;
  logic              ERR;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the port (-1 = nobody), who won last, how long held.
  int m_owner;
  int m_last;
  int m_held;
  bit m_err;

  port_arbiter2 #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .IN0(IN0), .IN1(IN1), .DONE(DONE),
    .GNT(GNT), .SEL(SEL), .OUT(OUT), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the arbitration rules to the inputs seen at this clock edge.
  task automatic model_edge();
    bit released, timed_out;
    int i;
    if (!RST_N) begin
      m_owner = -1; m_last = 1; m_held = 0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_owner < 0) begin
        m_held = 0;
        if (REQ == 2'b01)      m_owner = 0;
        else if (REQ == 2'b10) m_owner = 1;
        else if (REQ == 2'b11) m_owner = 1 - m_last;
      end else begin
        i = m_owner;
        released  = DONE || !REQ[i];
        timed_out = !released && (TIMEOUT != 0) && (m_held == TIMEOUT - 1);
        if (released || timed_out) begin
          m_last  = i;
          m_err   = timed_out;
          m_held  = 0;
          m_owner = REQ[1-i] ? (1 - i) : -1;
        end else begin
          m_held++;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [1:0] eg;
    eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    chk("gnt", GNT, eg);
    chk("sel", SEL, (m_owner == 1));
    chk("out", OUT, (m_owner == 1) ? IN1 : IN0);
    chk("busy", BUSY, (m_owner >= 0));
    chk("err", ERR, m_err);
  endtask

  // One clock: DUT and model both see the current inputs; check just after the edge.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    RST_N = 1'b0; REQ = 2'b11; DONE = 1'b0;
    IN0 = 32'h0000_0A0A; IN1 = 32'h0000_0B0B;
    m_owner = -1; m_last = 1; m_held = 0; m_err = 1'b0;

    // Reset held two cycles with both requesting.
    step(); step();
    chk("rst_gnt", GNT, 2'b00);
    chk("rst_sel", SEL, 1'b0);
    chk("rst_err", ERR, 1'b0);
    RST_N = 1'b1;
    step();
    chk("first_tie_gnt", GNT, 2'b01);
    DONE = 1'b1;
    step();
    chk("b2b_gnt", GNT, 2'b10);
    REQ = 2'b00; DONE = 1'b0;
    step();
    chk("idle_gnt", GNT, 2'b00);

    // Single request from requester 1.
    REQ = 2'b10; IN1 = 32'hDEAD_BEEF;
    step();
    chk("single_gnt", GNT, 2'b10);
    chk("single_sel", SEL, 1'b1);
    chk("single_out", OUT, 32'hDEAD_BEEF);
    DONE = 1'b1;
    step();
    chk("single_done_gnt", GNT, 2'b00);
    REQ = 2'b00; DONE = 1'b0;
    step();

    // Round robin: REQ=11 held, DONE on every third owned cycle.
    REQ = 2'b11;
    step();
    chk("rr_start", GNT, 2'b01);
    for (int g = 0; g < 4; g++) begin
      DONE = 1'b0;
      step(); step();
      chk("rr_hold", GNT, (g % 2 == 0) ? 2'b01 : 2'b10);
      DONE = 1'b1;
      step();
      chk("rr_next", GNT, (g % 2 == 0) ? 2'b10 : 2'b01);
    end
    REQ = 2'b00; DONE = 1'b0;
    step();
    chk("rr_end", GNT, 2'b00);

    // Abort: requester 0 drops its request while requester 1 waits.
    REQ = 2'b01;
    step();
    chk("abort_own0", GNT, 2'b01);
    REQ = 2'b10;
    step();
    chk("abort_gnt", GNT, 2'b10);
    chk("abort_err", ERR, 1'b0);
    REQ = 2'b00;
    step();

    // Watchdog expiry after TIMEOUT owned cycles.
    REQ = 2'b01;
    for (int c = 0; c < TIMEOUT; c++) begin
      step();
      chk("wd_hold", GNT, 2'b01);
      chk("wd_noerr", ERR, 1'b0);
    end
    step();
    chk("wd_err", ERR, 1'b1);
    chk("wd_gnt", GNT, 2'b00);
    REQ = 2'b00;
    step();
    chk("wd_err_pulse", ERR, 1'b0);

    // DONE on the last allowed cycle is a normal release.
    REQ = 2'b01;
    for (int c = 0; c < TIMEOUT; c++) step();
    DONE = 1'b1;
    step();
    chk("wd_done_err", ERR, 1'b0);
    chk("wd_done_gnt", GNT, 2'b00);
    REQ = 2'b00; DONE = 1'b0;
    step();

    // Reset in the middle of an OWN1 grant, together with DONE.
    REQ = 2'b10;
    step();
    chk("mid_own1", GNT, 2'b10);
    RST_N = 1'b0; DONE = 1'b1;
    step();
    chk("mid_rst_gnt", GNT, 2'b00);
    chk("mid_rst_sel", SEL, 1'b0);
    RST_N = 1'b1; DONE = 1'b0; REQ = 2'b11;
    step();
    chk("mid_rst_tie", GNT, 2'b01);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 4) REQ = 2'($urandom_range(0, 3));
      DONE  = ($urandom_range(0, 3) == 0);
      RST_N = ($urandom_range(0, 59) != 0);
      IN0   = $urandom;
      IN1   = $urandom;
      step();
      chk("onehot", (GNT != 2'b11), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
